// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply and divide producing HI/LO, one bit per clock
module mult_div_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
  state_t             r_state, w_next;
  logic [1:0]         r_op;
  logic               r_sa, r_sb, r_div_zero;
  logic [WIDTH-1:0]   r_opd, r_acc_hi, r_acc_lo, r_hi, r_lo;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_signed, w_dz, w_neg_q, w_neg_r;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quot, w_rem;
  logic [WIDTH:0]     w_sum, w_add, w_shift, w_trial;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  assign w_signed   = ~i_op[0];
  assign w_abs_a    = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_abs_b    = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_dz       = i_op[1] && (i_b == '0);
  // Multiply step: conditional add of the multiplicand into the upper half, carry kept in bit WIDTH
  assign w_sum      = {1'b0, r_acc_hi} + {1'b0, r_opd};
  assign w_add      = r_acc_lo[0] ? w_sum : {1'b0, r_acc_hi};
  // Divide step: shift the partial remainder left and trial-subtract the divisor
  assign w_shift    = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_opd};
  assign w_neg_q    = ~r_op[0] && (r_sa ^ r_sb);
  assign w_neg_r    = ~r_op[0] && r_sa;
  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = w_neg_q ? -w_prod : w_prod;
  assign w_quot     = w_neg_q ? -r_acc_lo : r_acc_lo;
  assign w_rem      = w_neg_r ? -r_acc_hi : r_acc_hi;
  assign o_div_zero = r_div_zero;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end
  // Next-state and handshake outputs
  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_IDLE: w_next = i_start ? (w_dz ? S_DONE : S_RUN) : S_IDLE;
      S_RUN: begin
        o_busy = 1'b1;
        w_next = (r_cnt == CNT_W'(1)) ? S_FIX : S_RUN;
      end
      S_FIX: begin
        o_busy = 1'b1;
        w_next = S_DONE;
      end
      default: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end
  // Operand capture, iteration datapath and sign-corrected result write-back
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op       <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_div_zero <= 1'b0;
      r_opd      <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_op       <= i_op;
          r_div_zero <= w_dz;
          if (!w_dz) begin
            r_sa     <= w_signed && i_a[WIDTH-1];
            r_sb     <= w_signed && i_b[WIDTH-1];
            r_opd    <= i_op[1] ? w_abs_b : w_abs_a;
            r_acc_hi <= '0;
            r_acc_lo <= i_op[1] ? w_abs_a : w_abs_b;
            r_cnt    <= CNT_W'(WIDTH);
          end
        end
        S_RUN: begin
          r_cnt    <= r_cnt - CNT_W'(1);
          r_acc_hi <= r_op[1] ? (w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0])
                              : w_add[WIDTH:1];
          r_acc_lo <= r_op[1] ? {r_acc_lo[WIDTH-2:0], ~w_trial[WIDTH]}
                              : {w_add[0], r_acc_lo[WIDTH-1:1]};
        end
        S_FIX: begin
          r_hi <= r_op[1] ? w_rem  : w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= r_op[1] ? w_quot : w_prod_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit with directed vectors
module tb_mult_div_unit;
  typedef struct {logic [31:0] hi; logic [31:0] lo; logic dz;} exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  int          total = 0, bad = 0;
  exp_t        sbq[$];
  mult_div_unit #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_div_zero(div_zero), .o_hi(hi), .o_lo(lo)
  );
  always #5 clk = ~clk;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  // Monitor: every done pulse is matched against the oldest expected result
  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_zero", div_zero, e.dz);
      end
    end
  end
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 100) begin
      if (busy) nb++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz);
    int n, nb;
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    sbq.push_back('{eh, el, edz});
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom_range(3));
    a = $urandom;
    b = $urandom;
    chk("div_zero_at_accept", div_zero, edz);
    wait_done(n, nb);
    chk("latency", n, edz ? 0 : 33);
    chk("busy_cycles", nb, edz ? 0 : 33);
    @(posedge clk);
  endtask
  initial begin
    int n, nb;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {busy, done, div_zero, hi, lo}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 1'b0);
    run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    run_op(2'b11, 32'd100, 32'd0, 32'd0, 32'd12, 1'b1);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    run_op(2'b00, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'd0, 32'd20, 1'b0);
    run_op(2'b10, 32'd5, 32'd7, 32'd5, 32'd0, 1'b0);
    run_op(2'b10, 32'd5, 32'd0, 32'd5, 32'd0, 1'b1);
    // Start held high through a whole operation: exactly one result, then an idle cycle
    @(negedge clk);
    start = 1'b1;
    op = 2'b00;
    a = 32'd2;
    b = 32'd3;
    sbq.push_back('{32'd0, 32'd6, 1'b0});
    @(posedge clk);
    #1;
    wait_done(n, nb);
    chk("hold_latency", n, 33);
    @(posedge clk);
    #1;
    chk("hold_idle", {busy, done}, 0);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_no_restart", {busy, done}, 0);
    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    a = 32'h12345678;
    b = 32'h9ABCDEF0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out", {busy, done, hi, lo}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b01, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide engine that produces the HI and LO register values for the multicycle datapath.
- Executes signed and unsigned multiply and divide in one unified shift/add-subtract loop, one bit per clock.
- The main control FSM talks to it through a start/busy/done handshake and writes its outputs into the HI/LO registers.
- Adds a divide-by-zero flag that the control unit uses to raise an exception and save PC to EPC.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits wide (minimum 4).
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived, not overridden).

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  reset; one clock; reset is asynchronous and active-low.
start  input  1  request pulse; sampled only in IDLE.
op  input  2  00 = MULT signed, 01 = MULTU, 10 = DIV signed, 11 = DIVU; sampled with start.
a  input  WIDTH  multiplicand / dividend (normally A_out); sampled with start.
b  input  WIDTH  multiplier / divisor (normally B_out); sampled with start.
busy  output  1  high in RUN and FIX.
done  output  1  one-cycle pulse in DONE; hi/lo/div_zero are valid while it is high.
div_zero  output  1  set with done when a DIV/DIVU divisor is 0; cleared when the next start is accepted.
hi  output  WIDTH  MULT: upper product half; DIV: remainder.
lo  output  WIDTH  MULT: lower product half; DIV: quotient.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state goes to IDLE; busy = 0, done = 0, div_zero = 0.
  - hi = 0, lo = 0, counter = 0, all internal operand/accumulator registers = 0.
  - Reset mid-operation aborts immediately; no partial result ever reaches hi/lo.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On start = 1 at edge E0, latch op.
  - For signed ops, latch |a| and |b|, and latch the sign bits a[WIDTH-1] and b[WIDTH-1].
  - For unsigned ops, latch a and b unchanged.
  - Load counter = WIDTH, clear div_zero, go to RUN.
  - Exception: if op is DIV/DIVU and b == 0, set div_zero = 1 and go to DONE directly; hi/lo are not modified.
- RUN: one iteration per edge; counter decrements; when counter reaches 1 at the iteration edge, go to FIX, so exactly WIDTH iterations run.
  - Multiply (shift-add): if the multiplier LSB is 1, add the multiplicand to the upper accumulator with a carry bit kept; then shift the {carry, acc_hi, acc_lo} register right by 1.
  - Divide (restoring): shift {rem, quot} left by 1; trial = rem - divisor (WIDTH+1 bits). If trial is non-negative, rem = trial and quot LSB = 1, else quot LSB = 0.
- FIX (one edge): sign correction, then write hi/lo and go to DONE.
  - Signed MULT: negate the 2*WIDTH-bit product if the two operand signs differ.
  - Signed DIV: negate the quotient if the signs differ; negate the remainder if the dividend was negative. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN / -1 (e.g. 0x80000000 / 0xFFFFFFFF): lo = MIN (two's-complement wrap), hi = 0, no flag.
- DONE: done = 1 for exactly one cycle, then IDLE unconditionally.
- Latency: with start sampled at edge E0, done is high during the cycle after edge E(WIDTH+1). Divide-by-zero: done is high during the cycle after E0.
- Handshake:
  - start while busy = 1 or done = 1 is ignored; no queuing.
  - op/a/b may change freely after E0.
- Holding outputs:
  - hi/lo hold their value until the next successful FIX; they are unaffected by a div-by-zero operation.
  - div_zero holds until the next accepted start.
- Arithmetic: all internal adders are WIDTH+1 bits; the product path is 2*WIDTH+1 bits; no overflow flag is produced for any op.

Test Plan (WIDTH = 32):
1. MULT, a = 0xFFFFFFFD (-3), b = 5 -> done 33 edges after start, hi = 0xFFFFFFFF, lo = 0xFFFFFFF1, div_zero = 0, busy high for 33 cycles.
2. MULTU, a = b = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
3. DIV, a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1); then DIVU with the same operands -> lo = 0x7FFFFFFC, hi = 0x00000001.
4. Preload hi/lo via MULTU 3*4 (hi = 0, lo = 12); then DIVU a = 100, b = 0 -> done on the cycle after the start edge, div_zero = 1, hi = 0, lo = 12 unchanged; next accepted start clears div_zero.
5. DIV, a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0x00000000, div_zero = 0.
6. Hold start high through a whole MULT; no second operation may start (done pulses once, then idles one cycle before re-accepting). Start a new op and drive reset = 0 at RUN iteration 10 -> busy, done, hi and lo all 0 immediately without waiting for a clock edge; after release, a fresh MULTU 7*6 gives lo = 42.
